// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

    localparam int unsigned SLOT_COUNT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } scan_state_e;

    // Raw active-high patterns, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_decoder.sv
// BCD to raw active-high segment pattern {a..g, dp}; non-BCD codes and blank give no segments.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    logic [6:0] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_BLANK;
            endcase
        end
        seg_o = {pattern, dp_i};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller with per-frame snapshot and dead time between slots.
// Define SEG_SCAN_LZB_EN to blank leading zeros in slots 3..1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV           = 1000,
    parameter int unsigned BLANK_CYCLES       = 16,
    parameter bit          INVERT_SEGMENT_OUT = 1'b1,
    parameter bit          INVERT_DIGIT_OUT   = 1'b0
) (
    input  logic        clkIn,
    input  logic        resetNIn,
    input  logic        enableIn,
    input  logic [15:0] digitsIn,
    input  logic [3:0]  dotsIn,
    output logic [7:0]  segmentEnableOut,
    output logic [3:0]  digitEnableOut,
    output logic [1:0]  slotOut,
    output logic        frameStartOut
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam bit         NO_BLANK = (BLANK_CYCLES == 0);
    localparam logic [7:0] SEG_OFF  = INVERT_SEGMENT_OUT ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_OFF  = INVERT_DIGIT_OUT ? 4'hF : 4'h0;

    scan_state_e      state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      snap_digits_q, snap_digits_d;
    logic [3:0]       snap_dots_q, snap_dots_d;
    logic             frame_d, lit_d, blank_d;
    logic [3:0]       digit_sel;
    logic [7:0]       raw_seg, seg_d;
    logic [3:0]       dig_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        cnt_d         = cnt_q;
        snap_digits_d = snap_digits_q;
        snap_dots_d   = snap_dots_q;
        frame_d       = 1'b0;
        if (!enableIn) begin
            state_d = StIdle;
            slot_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    frame_d       = 1'b1;
                    snap_digits_d = digitsIn;
                    snap_dots_d   = dotsIn;
                    slot_d        = '0;
                    cnt_d         = '0;
                    state_d       = NO_BLANK ? StShow : StBlank;
                end
                StBlank: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StShow: begin
                    if (cnt_q == SHOW_LAST) begin
                        slot_d  = slot_q + 2'd1;
                        cnt_d   = '0;
                        state_d = NO_BLANK ? StShow : StBlank;
                        if (slot_q == 2'd3) begin
                            frame_d       = 1'b1;
                            snap_digits_d = digitsIn;
                            snap_dots_d   = dotsIn;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Without dead time, the first SHOW cycle stays dark so the old and new digit never overlap.
    assign lit_d     = (state_d == StShow) && !(NO_BLANK && (cnt_d == '0));
    assign digit_sel = snap_digits_d[{slot_d, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        blank_d = (slot_d != 2'd0);
        for (int i = 1; i < SLOT_COUNT; i++) begin
            if ((i >= int'(slot_d)) && (snap_digits_d[4*i +: 4] != 4'd0)) begin
                blank_d = 1'b0;
            end
        end
    end
`else
    assign blank_d = 1'b0;
`endif

    seg_decoder u_decoder (
        .bcd_i   (digit_sel),
        .dp_i    (snap_dots_d[slot_d]),
        .blank_i (blank_d),
        .seg_o   (raw_seg)
    );

    assign seg_d = lit_d ? (raw_seg ^ SEG_OFF) : SEG_OFF;
    assign dig_d = lit_d ? ((4'b0001 << slot_d) ^ DIG_OFF) : DIG_OFF;

    always_ff @(posedge clkIn or negedge resetNIn) begin
        if (!resetNIn) begin
            state_q          <= StIdle;
            slot_q           <= '0;
            cnt_q            <= '0;
            snap_digits_q    <= '0;
            snap_dots_q      <= '0;
            segmentEnableOut <= SEG_OFF;
            digitEnableOut   <= DIG_OFF;
            slotOut          <= '0;
            frameStartOut    <= 1'b0;
        end else begin
            state_q          <= state_d;
            slot_q           <= slot_d;
            cnt_q            <= cnt_d;
            snap_digits_q    <= snap_digits_d;
            snap_dots_q      <= snap_dots_d;
            segmentEnableOut <= seg_d;
            digitEnableOut   <= dig_d;
            slotOut          <= slot_d;
            frameStartOut    <= frame_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: two configurations against a frame-arithmetic model.
module tb_seg_scan_ctrl;

    localparam int S_A = 4;
    localparam int B_A = 1;
    localparam int S_B = 4;
    localparam int B_B = 0;
    localparam int P_A = 4 * (S_A + B_A);
    localparam int P_B = 4 * (S_B + B_B);
`ifdef SEG_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;
    logic [1:0]  slot_a, slot_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .SCAN_DIV(S_A), .BLANK_CYCLES(B_A), .INVERT_SEGMENT_OUT(1'b1), .INVERT_DIGIT_OUT(1'b0)
    ) dut_a (
        .clkIn(clk), .resetNIn(rst_n), .enableIn(en), .digitsIn(digits), .dotsIn(dots),
        .segmentEnableOut(seg_a), .digitEnableOut(dig_a), .slotOut(slot_a), .frameStartOut(fs_a)
    );

    seg_scan_ctrl #(
        .SCAN_DIV(S_B), .BLANK_CYCLES(B_B), .INVERT_SEGMENT_OUT(1'b0), .INVERT_DIGIT_OUT(1'b1)
    ) dut_b (
        .clkIn(clk), .resetNIn(rst_n), .enableIn(en), .digitsIn(digits), .dotsIn(dots),
        .segmentEnableOut(seg_b), .digitEnableOut(dig_b), .slotOut(slot_b), .frameStartOut(fs_b)
    );

    int errors = 0;
    int checks = 0;

    // Model: cycles elapsed since the enabling edge, plus each configuration's frame snapshot.
    bit          run;
    int          k;
    logic [15:0] snap_a, snap_b;
    logic [3:0]  sdots_a, sdots_b;
    logic [3:0]  prev_a, prev_b;

    typedef struct {
        logic [3:0] digit;
        logic       dot;
        logic [7:0] seg_a;
        logic [7:0] seg_b;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_out(input int s_div, input int b_cyc, input bit inv_seg,
                             input bit inv_dig, input logic [15:0] snap, input logic [3:0] sd,
                             output logic [7:0] seg, output logic [3:0] dig,
                             output logic [1:0] slot, output logic fs);
        int p, pos, s, w, d;
        logic [7:0] rs;
        logic [3:0] rd;
        rs = '0;
        rd = '0;
        slot = '0;
        fs = 1'b0;
        if (run) begin
            p = 4 * (s_div + b_cyc);
            pos = k % p;
            s = pos / (s_div + b_cyc);
            w = pos % (s_div + b_cyc);
            slot = 2'(s);
            fs = (pos == 0);
            if (w >= b_cyc && !(b_cyc == 0 && w == 0)) begin
                rd = 4'(1 << s);
                d = int'((snap >> (4 * s)) & 16'h000F);
                rs = {(LZB && s != 0 && (snap >> (4 * s)) == 16'h0) ? 7'b0 : pat(d), sd[s]};
            end
        end
        seg = inv_seg ? ~rs : rs;
        dig = inv_dig ? ~rd : rd;
    endtask

    task automatic compare_all();
        logic [7:0] es;
        logic [3:0] ed, raw_a, raw_b;
        logic [1:0] el;
        logic       ef;
        model_out(S_A, B_A, 1'b1, 1'b0, snap_a, sdots_a, es, ed, el, ef);
        check("seg_a", seg_a, es);
        check("dig_a", dig_a, ed);
        check("slot_a", slot_a, el);
        check("frame_a", fs_a, ef);
        model_out(S_B, B_B, 1'b0, 1'b1, snap_b, sdots_b, es, ed, el, ef);
        check("seg_b", seg_b, es);
        check("dig_b", dig_b, ed);
        check("slot_b", slot_b, el);
        check("frame_b", fs_b, ef);
        raw_a = dig_a;
        raw_b = ~dig_b;
        check("onehot_a", ($countones(raw_a) <= 1), 1);
        check("onehot_b", ($countones(raw_b) <= 1), 1);
        check("handover_a", (prev_a != 0 && raw_a != 0 && prev_a != raw_a), 0);
        check("handover_b", (prev_b != 0 && raw_b != 0 && prev_b != raw_b), 0);
        prev_a = raw_a;
        prev_b = raw_b;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            run = 0;
            snap_a = '0;
            snap_b = '0;
            sdots_a = '0;
            sdots_b = '0;
        end else if (!en) begin
            run = 0;
        end else begin
            if (!run) begin
                run = 1;
                k = 0;
            end else begin
                k++;
            end
            if (k % P_A == 0) begin
                snap_a = digits;
                sdots_a = dots;
            end
            if (k % P_B == 0) begin
                snap_b = digits;
                sdots_b = dots;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic restart(input logic [15:0] dg, input logic [3:0] dt);
        en = 1'b0;
        step();
        digits = dg;
        dots = dt;
        en = 1'b1;
    endtask

    int fa[$];
    int fb[$];
    logic [1:0] sq[$];

    initial begin
        tbl[0] = '{4'd4,  1'b0, 8'h99, 8'h66};
        tbl[1] = '{4'd0,  1'b1, 8'h02, 8'hFD};
        tbl[2] = '{4'd8,  1'b0, 8'h01, 8'hFE};
        tbl[3] = '{4'd7,  1'b1, 8'h1E, 8'hE1};
        tbl[4] = '{4'd10, 1'b1, 8'hFE, 8'h01};
        tbl[5] = '{4'd15, 1'b0, 8'hFF, 8'h00};
        tbl[6] = '{4'd2,  1'b0, 8'h25, 8'hDA};
        tbl[7] = '{4'd9,  1'b1, 8'h08, 8'hF7};

        rst_n = 1'b0; en = 1'b0; digits = '0; dots = '0;
        run = 0; k = 0; snap_a = '0; snap_b = '0; sdots_a = '0; sdots_b = '0;
        prev_a = '0; prev_b = '0;
        #12;
        check("rst_seg_a", seg_a, 8'hFF);
        check("rst_dig_a", dig_a, 4'h0);
        check("rst_seg_b", seg_b, 8'h00);
        check("rst_dig_b", dig_b, 4'hF);
        check("rst_slot_a", slot_a, 2'd0);
        check("rst_frame_a", fs_a, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step(); step();

        // Slot-0 decode table; slot 0 is lit in both configurations at k = 1.
        for (int i = 0; i < 8; i++) begin
            restart({12'h000, tbl[i].digit}, {3'b000, tbl[i].dot});
            step(); step();
            check("tbl_seg_a", seg_a, tbl[i].seg_a);
            check("tbl_dig_a", dig_a, 4'b0001);
            check("tbl_seg_b", seg_b, tbl[i].seg_b);
            check("tbl_dig_b", dig_b, 4'b1110);
        end

        // Frame period, slot order and mid-frame snapshot isolation.
        restart(16'h1234, 4'h0);
        for (int i = 0; i < 45; i++) begin
            step();
            if (fs_a) fa.push_back(i);
            if (fs_b) fb.push_back(i);
            if (i == 0 || slot_a != sq[$]) sq.push_back(slot_a);
            if (i == 7) digits = 16'h5678;
            if (i == 11) check("snap_old_slot2", seg_a, 8'h25);
            if (i == 31) check("snap_new_slot2", seg_a, 8'h41);
        end
        check("fs_a_count", fa.size(), 3);
        check("fs_a_first", (fa.size() > 0) ? fa[0] : -1, 0);
        if (fa.size() >= 2) check("fs_a_period", fa[1] - fa[0], 20);
        check("fs_b_count", fb.size(), 3);
        if (fb.size() >= 2) check("fs_b_period", fb[1] - fb[0], 16);
        check("slot_order_len", (sq.size() >= 5), 1);
        for (int j = 0; j < 5; j++) begin
            if (j < sq.size()) check("slot_order", sq[j], (j == 4) ? 0 : j);
        end

        // Invalid codes with slot-0 dp.
        restart(16'h00AF, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) check("inv_slot0_dp", seg_a, 8'hFE);
            if (i == 7) check("inv_slot1_off", seg_a, 8'hFF);
        end

        // Disable mid-SHOW in slot 2.
        restart(16'h1234, 4'h0);
        for (int i = 0; i < 13; i++) step();
        check("pre_dis_dig", dig_a, 4'b0100);
        en = 1'b0;
        step();
        check("dis_dig", dig_a, 4'h0);
        check("dis_slot", slot_a, 2'd0);
        check("dis_seg", seg_a, 8'hFF);

        // Asynchronous reset mid-SHOW darkens before the next edge.
        en = 1'b1;
        for (int i = 0; i < 13; i++) step();
        check("pre_rst_dig", dig_a, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_seg_a", seg_a, 8'hFF);
        check("arst_dig_a", dig_a, 4'h0);
        check("arst_slot_a", slot_a, 2'd0);
        check("arst_dig_b", dig_b, 4'hF);
        check("arst_seg_b", seg_b, 8'h00);
        step();
        rst_n = 1'b1;
        step(); step();

        // Zero dead time: leading-zero handling and 16-cycle frame.
        restart(16'h0050, 4'h0);
        fb.delete();
        for (int i = 0; i < 17; i++) begin
            step();
            if (fs_b) fb.push_back(i);
            if (i == 1) check("lz_slot0", seg_b, 8'hFC);
            if (i == 5) check("lz_slot1", seg_b, 8'hB6);
            if (i == 9) check("lz_slot2", seg_b, LZB ? 8'h00 : 8'hFC);
            if (i == 13) check("lz_slot3", seg_b, LZB ? 8'h00 : 8'hFC);
        end
        check("lz_fs_count", fb.size(), 2);
        if (fb.size() >= 2) check("lz_period", fb[1] - fb[0], 16);

        // Randomised traffic with occasional disable and reset.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 100) digits = 16'($urandom);
            if (r >= 100 && r < 150) dots = 4'($urandom);
            if (r >= 150 && r < 170) en = ~en;
            if (!en && r >= 170 && r < 300) en = 1'b1;
            if (r < 3) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each digit is lit per slot; legal range 1..65535.
REQ-002 Parameter BLANK_CYCLES, default 16: dead-time cycles between slots with all digits off; legal range 0..255.
REQ-003 Parameter INVERT_SEGMENT_OUT, default 1: 1 makes segment outputs active-low, 0 makes them active-high.
REQ-004 Parameter INVERT_DIGIT_OUT, default 0: 1 makes digit enables active-low, 0 makes them active-high.
REQ-005 Ports SHALL be as follows.
- clkIn, input, 1: sole clock; one clock, all state on its rising edge.
- resetNIn, input, 1: reset, asynchronous assert, active-low.
- enableIn, input, 1: scan enable.
- digitsIn, input, 16: four BCD digits; [3:0] is slot 0 (rightmost).
- dotsIn, input, 4: decimal points; bit n belongs to slot n.
- segmentEnableOut, output, 8: [7:1] = a..g, [0] = dp.
- digitEnableOut, output, 4: one-hot common-pin drive.
- slotOut, output, 2: index of the slot currently lit or pending.
- frameStartOut, output, 1: one-cycle pulse when a frame snapshot is taken.

Function
REQ-006 FSM states SHALL be IDLE, BLANK and SHOW; the state register and all outputs SHALL be registered.
REQ-007 IDLE SHALL behave as follows.
- All digits and segments are at their inactive levels; slot = 0.
- enableIn = 1 moves to BLANK on the next edge, or to SHOW when BLANK_CYCLES = 0.
REQ-008 On every entry to slot 0, including from IDLE, the block SHALL snapshot digitsIn and dotsIn into an internal register and pulse frameStartOut for exactly one cycle.
REQ-009 Displayed data SHALL come only from the snapshot; input changes mid-frame SHALL have no effect until the next frame.
REQ-010 BLANK SHALL last exactly BLANK_CYCLES cycles with all digits and segments inactive, then go to SHOW.
REQ-011 SHOW SHALL last exactly SCAN_DIV cycles with the following outputs.
- digitEnableOut asserts only bit slotOut.
- segmentEnableOut carries the decoded snapshot digit and dp.
REQ-012 At the end of SHOW, slot SHALL increment modulo 4 (3 -> 0) and the FSM SHALL enter BLANK, or SHOW directly when BLANK_CYCLES = 0.
REQ-013 One frame SHALL take exactly 4*(BLANK_CYCLES+SCAN_DIV) cycles.
REQ-014 BCD values 0..9 SHALL decode to standard a..g patterns; values 10..15 SHALL decode to all segments off, with dp still per snapshot.
REQ-015 Digit and segment enables SHALL never both be active outside SHOW.
REQ-016 The slot-change edge SHALL deassert the old digit and assert the new digit on different cycles, even when BLANK_CYCLES = 0.
- The segment update coincides with the new digit enable.
REQ-017 enableIn = 0 in any state SHALL force IDLE on the next edge, with outputs inactive and slot reset to 0; the partial frame is discarded.
REQ-018 The slot and cycle counters SHALL be sized from the parameters and SHALL never overflow.

Reset
REQ-019 resetNIn low SHALL immediately force the following, independent of clkIn.
- state = IDLE, slot = 0, counters = 0, snapshot = 0.
- frameStartOut = 0; segments and digit enables at their inactive levels.
REQ-020 Reset asserted mid-SHOW SHALL darken the display in the same cycle.
REQ-021 Operation after reset release SHALL begin from IDLE per REQ-007.

Configuration
REQ-022 With macro SEG_SCAN_LZB_EN defined, leading zeros in the snapshot SHALL be blanked, with these rules.
- Blanking applies to slots 3..1 (the most significant zero digits) until the first nonzero digit.
- Slot 0 is never blanked.
- A blanked slot still honours its dp bit.
- Blanked slots keep their full SHOW timing.
REQ-023 Without SEG_SCAN_LZB_EN, all four slots SHALL display their decoded digits and no blanking logic SHALL exist.

Structure
REQ-024 Package seg_pkg SHALL hold the following.
- The scan-state enum typedef.
- The 7-bit segment pattern constants for 0..9 and blank.
- The slot-count constant, value 4.
REQ-025 A combinational sub-module seg_decoder SHALL perform the following mapping.
- Inputs: 4-bit BCD, dp, blank.
- Output: 8-bit raw segment pattern.
- Inversion is applied in seg_scan_ctrl.

Verification
Scenarios use SCAN_DIV = 4 and BLANK_CYCLES = 1 unless stated.
REQ-026 Reset then enable: enableIn = 1 with digitsIn = 16'h1234 -> the following are required.
- frameStartOut pulses once.
- Slot order is 0, 1, 2, 3, 0.
- Slot 0 shows "4" as a..g = 0110011, so segmentEnableOut[7:1] = 1001100 with inversion.
- Frame period is 20 cycles.
REQ-027 Snapshot: change digitsIn from 16'h1234 to 16'h5678 during slot 1 -> the frame completes with 1234 digits; 5678 appears only after the next frameStartOut.
REQ-028 Invalid/dp: digitsIn = 16'h00AF, dotsIn = 4'b0001 -> slots 0 and 1 show all segments off, and slot 0 has dp active.
REQ-029 Disable/reset mid-SHOW: enableIn = 0 during slot 2 -> the next cycle is IDLE with digitEnableOut inactive; resetNIn low asynchronously -> outputs are inactive before the next clkIn edge.
REQ-030 BLANK_CYCLES = 0 with SEG_SCAN_LZB_EN defined, digitsIn = 16'h0050 -> the following are required.
- Slots 3 and 2 are blank, and slots 1 and 0 show "5" and "0".
- No cycle has two digits enabled.
- Frame period is 16 cycles.
